// File: rtl/sel_seq_pkg.sv
// Shared types and constants for the select sequencer: select codes, FSM states
// and the command record buffered in the FIFO.
package sel_seq_pkg;

   typedef enum logic [1:0] {
      SEL_BC   = 2'b00,
      SEL_OFF  = 2'b01,
      SEL_ABC  = 2'b10,
      SEL_OFF2 = 2'b11
   } sel_code_t;

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   localparam int unsigned CNT_W = 4;

   typedef struct packed {
      sel_code_t        code;
      logic [CNT_W-1:0] rep;
   } cmd_t;

   // Decoder drives a/b/c all low for this code, so it is safe to show when idle.
   localparam sel_code_t SEL_IDLE_CODE = SEL_OFF;

endpackage

// File: rtl/sel_sequencer_if.sv
// Command push channel and select-beat channel of the sequencer.
// The sequencer sits on the slave modport; the command source/beat sink on master.
interface sel_sequencer_if #(
   parameter int unsigned CNT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_code;
   logic [CNT_W-1:0] cmd_rep;
   logic [1:0]       s;
   logic             s_valid;
   logic             s_ready;

   modport master (
      output cmd_valid, cmd_code, cmd_rep, s_ready,
      input  cmd_ready, s, s_valid
   );

   modport slave (
      input  cmd_valid, cmd_code, cmd_rep, s_ready,
      output cmd_ready, s, s_valid
   );
endinterface

// File: rtl/sel_seq_fifo.sv
// Synchronous command FIFO with extra-MSB pointers for full/empty detection.
// Head entry is presented combinationally on rdata whenever not empty.
module sel_seq_fifo import sel_seq_pkg::*; #(
   parameter int unsigned DEPTH = 4,
   parameter type item_t = cmd_t
) (
   input  logic  clk,
   input  logic  aresetn,
   input  logic  push,
   input  item_t wdata,
   input  logic  pop,
   output item_t rdata,
   output logic  full,
   output logic  empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wptr_q, rptr_q;
   item_t       mem [DEPTH];

   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign rdata = mem[rptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         // A push while full is dropped even if a pop frees a slot this cycle.
         if (push && !full) wptr_q <= wptr_q + (AW+1)'(1);
         if (pop && !empty) rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wptr_q[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/sel_sequencer.sv
// Command-driven generator of the 2-bit decoder select; each queued code is emitted for
// rep+1 beats. Define SEL_SEQ_STATS_EN to add per-code saturating beat counters.
module sel_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 aresetn,
   sel_sequencer_if.slave       bus,
   output logic                 busy
`ifdef SEL_SEQ_STATS_EN
   ,
   input  logic                 stat_clr,
   output logic [3:0][15:0]     stat_cnt
`endif
);
   import sel_seq_pkg::*;

   typedef struct packed {
      sel_code_t        code;
      logic [CNT_W-1:0] rep;
   } entry_t;

   state_t           state_q, state_d;
   sel_code_t        code_q, code_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   entry_t           push_data, head;
   logic             full, empty, push, pop, beat;

   assign push          = bus.cmd_valid && !full;
   assign bus.cmd_ready = !full;
   assign push_data     = '{code: sel_code_t'(bus.cmd_code), rep: bus.cmd_rep};

   sel_seq_fifo #(
      .DEPTH  (DEPTH),
      .item_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .aresetn (aresetn),
      .push    (push),
      .wdata   (push_data),
      .pop     (pop),
      .rdata   (head),
      .full    (full),
      .empty   (empty)
   );

   // Outputs decode registered state only; s_ready never reaches s/s_valid.
   assign bus.s_valid = (state_q == EMIT);
   assign bus.s       = (state_q == EMIT) ? code_q : SEL_IDLE_CODE;
   assign beat        = (state_q == EMIT) && bus.s_ready;
   assign busy        = !empty || (state_q == EMIT);

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      rem_d   = rem_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               code_d  = head.code;
               rem_d   = head.rep;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (bus.s_ready) begin
               if (rem_q != '0) begin
                  rem_d = rem_q - CNT_W'(1);
               end else if (!empty) begin
                  // Chain straight into the next command without an idle beat.
                  pop    = 1'b1;
                  code_d = head.code;
                  rem_d  = head.rep;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         code_q  <= SEL_IDLE_CODE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         rem_q   <= rem_d;
      end
   end

`ifdef SEL_SEQ_STATS_EN
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         stat_cnt <= '0;
      end else if (stat_clr) begin
         stat_cnt <= '0;
      end else if (beat && (stat_cnt[bus.s] != 16'hFFFF)) begin
         stat_cnt[bus.s] <= stat_cnt[bus.s] + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_sel_sequencer.sv
// Randomized bench for sel_sequencer against a queue-based model of pending commands
// and beats left in the command on display.
module tb_sel_sequencer;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 4;

   typedef struct {
      int code;
      int rep;
   } mcmd_t;

   logic clk = 1'b0;
   logic aresetn;
   logic busy;
   int   n_checks = 0;
   int   n_errors = 0;

   // Model state: commands accepted but not yet on display, and the one on display.
   mcmd_t mq[$];
   int    cur_left;
   int    cur_code;
   int    beats_exp;
   int    beats_got;
   int    stat_m[4];

   always #5 clk = ~clk;

   sel_sequencer_if #(.CNT_W(CNT_W)) bus ();

`ifdef SEL_SEQ_STATS_EN
   logic            stat_clr;
   logic [3:0][15:0] stat_cnt;
`endif

   sel_sequencer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .aresetn  (aresetn),
      .bus      (bus),
      .busy     (busy)
`ifdef SEL_SEQ_STATS_EN
      ,
      .stat_clr (stat_clr),
      .stat_cnt (stat_cnt)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      cur_left  = 0;
      cur_code  = 1;
      beats_exp = 0;
      beats_got = 0;
      for (int k = 0; k < 4; k++) stat_m[k] = 0;
   endtask

   // Advance the model across one rising edge using the inputs the bench drove.
   task automatic model_edge();
      bit take, hs;
      take = bus.cmd_valid && (mq.size() < DEPTH);
      hs   = (cur_left > 0) && bus.s_ready;
`ifdef SEL_SEQ_STATS_EN
      if (stat_clr) begin
         for (int k = 0; k < 4; k++) stat_m[k] = 0;
      end else if (hs && stat_m[cur_code] < 65535) begin
         stat_m[cur_code]++;
      end
`endif
      if (hs) cur_left--;
      if (cur_left == 0 && mq.size() > 0) begin
         cur_code = mq[0].code;
         cur_left = mq[0].rep + 1;
         void'(mq.pop_front());
      end
      if (take) begin
         mq.push_back('{int'(bus.cmd_code), int'(bus.cmd_rep)});
         beats_exp += int'(bus.cmd_rep) + 1;
      end
   endtask

   task automatic check_outputs();
      check_eq("s_valid", bus.s_valid, (cur_left > 0));
      check_eq("s", bus.s, (cur_left > 0) ? cur_code : 1);
      check_eq("cmd_ready", bus.cmd_ready, (mq.size() < DEPTH));
      check_eq("busy", busy, (mq.size() > 0) || (cur_left > 0));
`ifdef SEL_SEQ_STATS_EN
      for (int k = 0; k < 4; k++) check_eq("stat_cnt", stat_cnt[k], stat_m[k]);
`endif
   endtask

   task automatic step();
      bit dut_beat;
      @(negedge clk);
      check_outputs();
      dut_beat = bus.s_valid && bus.s_ready;
      @(posedge clk);
      if (dut_beat) beats_got++;
      if (aresetn) model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      bus.cmd_valid = 1'b0;
      bus.cmd_code  = 2'b00;
      bus.cmd_rep   = '0;
      bus.s_ready   = 1'b1;
`ifdef SEL_SEQ_STATS_EN
      stat_clr      = 1'b0;
`endif
   endtask

   task automatic push_cmd(input int code, input int rep);
      bus.cmd_valid = 1'b1;
      bus.cmd_code  = 2'(code);
      bus.cmd_rep   = CNT_W'(rep);
      step();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      bus.cmd_valid = 1'b0;
      bus.s_ready   = 1'b1;
      while ((busy || bus.s_valid) && n < 200) begin
         step();
         n++;
      end
      check_eq("drain_done", busy, 1'b0);
      check_eq("beat_total", beats_got, beats_exp);
      step();
   endtask

   initial begin
      idle_inputs();
      aresetn = 1'b0;
      model_reset();
      repeat (3) step();
      aresetn = 1'b1;
      repeat (3) step();

      // Single command: three beats of 2'b10, two cycles after acceptance.
      push_cmd(2, 2);
      repeat (6) step();

      // Back-to-back commands chain without a gap.
      push_cmd(0, 0);
      push_cmd(2, 1);
      repeat (6) step();

      // Backpressure in the middle of a four-beat command.
      push_cmd(3, 3);
      step();
      step();
      bus.s_ready = 1'b0;
      repeat (4) step();
      bus.s_ready = 1'b1;
      drain();

      // Fill the FIFO while the sink stalls, then release.
      bus.s_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_code  = 2'(i);
         bus.cmd_rep   = CNT_W'(i % 3);
         step();
      end
      drain();

      // Longest command: all-ones repeat count.
      push_cmd(1, (1 << CNT_W) - 1);
      drain();

`ifdef SEL_SEQ_STATS_EN
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      push_cmd(0, 2);
      drain();
      check_eq("stat0_three", stat_cnt[0], 32'd3);
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      check_eq("stat0_cleared", stat_cnt[0], 32'd0);
`endif

      for (int i = 0; i < 1500; i++) begin
         bus.cmd_valid = ($urandom_range(0, 2) == 0);
         bus.cmd_code  = 2'($urandom_range(0, 3));
         bus.cmd_rep   = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 15))
                                                     : CNT_W'($urandom_range(0, 2));
         bus.s_ready   = ($urandom_range(0, 3) != 0);
`ifdef SEL_SEQ_STATS_EN
         stat_clr      = ($urandom_range(0, 99) == 0);
`endif
         step();
      end
      idle_inputs();
      drain();

      // Reset in the middle of activity flushes everything at once.
      push_cmd(2, 5);
      push_cmd(3, 1);
      push_cmd(0, 2);
      step();
      #2;
      aresetn = 1'b0;
      #1;
      check_eq("rst_async_s_valid", bus.s_valid, 1'b0);
      check_eq("rst_async_s", bus.s, 2'b01);
      check_eq("rst_async_busy", busy, 1'b0);
      check_eq("rst_async_ready", bus.cmd_ready, 1'b1);
      model_reset();
      repeat (2) step();
      aresetn = 1'b1;
      repeat (3) step();
      push_cmd(1, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
